// File: rtl/hazard_control_unit.sv
// Load-use / structural / taken-branch hazard controller beside the ID stage.
// Mealy outputs (same-cycle stall/flush); state, cnt and saturating statistics registered.
module hazard_control_unit #(
  parameter int REG_AW   = 5,
  parameter int INST_W   = 32,
  parameter int LOAD_LAT = 1,
  parameter int BR_FLUSH = 1,
  parameter int STAT_W   = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              MemRead_EX,
  input  logic [REG_AW-1:0] Rd_EX,
  input  logic [INST_W-1:0] IFID_inst,
  input  logic              rs1_used_ID,
  input  logic              rs2_used_ID,
  input  logic              mem_busy,
  input  logic              branch_taken_EX,
  output logic              stall,
  output logic              pc_WriteEnable,
  output logic              if_id_WriteEnable,
  output logic              id_ex_flush,
  output logic              if_id_flush,
  output logic [STAT_W-1:0] stall_cycles,
  output logic [STAT_W-1:0] flush_events
);

  typedef enum logic [1:0] {RUN, LOAD_STALL, FLUSH} state_t;

  state_t            state;
  logic [2:0]        cnt;
  logic [REG_AW-1:0] rs1;
  logic [REG_AW-1:0] rs2;
  logic              lu;
  logic              unused_inst_bits;

  assign rs1 = IFID_inst[15 +: REG_AW];
  assign rs2 = IFID_inst[20 +: REG_AW];
  assign unused_inst_bits = ^{IFID_inst[INST_W-1:20+REG_AW], IFID_inst[14:0]};

  // x0 is hardwired zero, so a load targeting it can never feed a consumer.
  assign lu = MemRead_EX && (Rd_EX != '0) &&
              ((rs1_used_ID && (Rd_EX == rs1)) || (rs2_used_ID && (Rd_EX == rs2)));

  always_comb begin
    stall             = 1'b0;
    pc_WriteEnable    = 1'b1;
    if_id_WriteEnable = 1'b1;
    id_ex_flush       = 1'b0;
    if_id_flush       = 1'b0;
    if (!rst) begin
      if (branch_taken_EX) begin
        if_id_flush = 1'b1;
        id_ex_flush = 1'b1;
      end else if (mem_busy) begin
        stall             = 1'b1;
        pc_WriteEnable    = 1'b0;
        if_id_WriteEnable = 1'b0;
      end else if ((state == LOAD_STALL) || ((state == RUN) && lu)) begin
        stall             = 1'b1;
        pc_WriteEnable    = 1'b0;
        if_id_WriteEnable = 1'b0;
        id_ex_flush       = 1'b1;
      end else if (state == FLUSH) begin
        if_id_flush = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= RUN;
      cnt          <= '0;
      stall_cycles <= '0;
      flush_events <= '0;
    end else begin
      if (stall && (stall_cycles != '1))
        stall_cycles <= stall_cycles + STAT_W'(1);

      if (branch_taken_EX) begin
        // A pending load stall belongs to the wrong path and is dropped.
        if (flush_events != '1)
          flush_events <= flush_events + STAT_W'(1);
        if (BR_FLUSH > 1) begin
          state <= FLUSH;
          cnt   <= 3'(BR_FLUSH - 1);
        end else begin
          state <= RUN;
          cnt   <= '0;
        end
      end else if (!mem_busy) begin
        // A busy memory port freezes state and cnt so no penalty cycle is lost.
        case (state)
          RUN: begin
            if (lu && (LOAD_LAT > 1)) begin
              state <= LOAD_STALL;
              cnt   <= 3'(LOAD_LAT - 1);
            end
          end
          LOAD_STALL, FLUSH: begin
            cnt <= cnt - 3'd1;
            if (cnt == 3'd1)
              state <= RUN;
          end
          default: begin
            state <= RUN;
            cnt   <= '0;
          end
        endcase
      end
    end
  end

endmodule
